simple_writeback: RTL and testbench
===================================

// Module: simple_writeback
// PURPOSE
//  Execute/writeback stage directly downstream of the 16-bit ALU. Registers ALU result and
//  SZCV, owns the architectural flag register, drives the register-file write port,
//  resolves conditional branches, and sequences OUT (output handshake) and HLT.
//  Single-entry pipeline register; upstream sees a valid/ready handshake.
// PARAMETERS
//  DATA_W  16  datapath width (matches ALU res)
//  RA_W    3   register-file address width (8 GPRs)
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       reset, asynchronous, active-low
//  in_valid      in   1       upstream instruction valid
//  in_ready      out  1       stage accepts; transfer when in_valid & in_ready
//  in_op         in   4       ALU op code (same encoding the ALU receives)
//  in_res        in   DATA_W  ALU result (IN: external input data)
//  in_szcv       in   4       ALU flags {S,Z,C,V}
//  in_rd         in   RA_W    destination register
//  in_is_br      in   1       instruction is a branch (in_op ignored)
//  in_cond       in   3       branch condition
//  in_br_target  in   DATA_W  branch target PC
//  rf_we         out  1       register-file write strobe (1-cycle pulse)
//  rf_waddr      out  RA_W    write address
//  rf_wdata      out  DATA_W  write data
//  flags         out  4       architectural SZCV register
//  br_taken      out  1       branch redirect pulse (1 cycle)
//  br_pc         out  DATA_W  redirect target
//  out_valid     out  1       OUT data valid
//  out_ready     in   1       OUT consumer ready
//  out_data      out  DATA_W  OUT data
//  halted        out  1       processor halted
//  resume        in   1       leave HALTED (pulse)
// BEHAVIOUR
//  Reset: all outputs 0, flags=0, state=RUN; async assert, clears any in-flight OUT/HLT.
//  States: RUN, OUT_WAIT, HALTED. in_ready = (state==RUN), combinational from state only.
//  Latency: instruction accepted at edge N -> rf_we/flags/br_taken/out_valid visible after N.
//  Register write (rf_we=1, waddr=in_rd, wdata=in_res): ops 0000-0100, 0110, 1000-1011, 1100.
//  Flag update (flags<=in_szcv): ops 0000-0110, 1000-1011. CMP(0101): flags only, no write.
//  0111, 1101(OUT), 1110, 1111(HLT), branches: no write, no flag update.
//  Branch (in_is_br=1): evaluated on flags register value at acceptance (pre-edge):
//   000 BE: Z; 001 BLT: S^V; 010 BLE: Z|(S^V); 011 BNE: !Z; 100 B: 1; 101-111: never.
//   taken -> br_taken=1, br_pc=in_br_target for one cycle; not taken -> br_taken=0.
//  Flag-setting op followed back-to-back by branch: branch sees the updated flags (update
//   happens at the earlier acceptance edge; no bypass needed).
//  OUT (1101): out_data<=in_res, out_valid<=1, RUN->OUT_WAIT. out_valid/out_data held stable
//   until out_valid&out_ready; then out_valid<=0, ->RUN. out_ready ignored when out_valid=0.
//  HLT (1111): RUN->HALTED, halted<=1. resume in HALTED -> RUN, halted<=0 next edge.
//   resume outside HALTED ignored.
//  rf_we, br_taken are single-cycle; 0 in any cycle without an acceptance on the prior edge.
//  No arithmetic in this block; widths pass through unchanged.
// STRUCTURE
//  Shared package simple_pkg: op-code constants (ADD..HLT), branch-cond constants,
//   state encoding, DATA_W/RA_W defaults; reused by decode and ALU wrappers.
//  Sub-module branch_cond_eval (combinational: flags, cond -> taken).
// TESTING
//  ADD res=0x0003 szcv=0000 rd=2 -> next cycle rf_we=1 waddr=2 wdata=0x0003, flags=0000.
//  CMP szcv=0100 then BE target=0x0040 back-to-back -> rf_we=0 for CMP, br_taken=1 br_pc=0x0040.
//  flags S=1,V=0: BLT taken, BLE taken, BNE taken, BE not; cond 101 never taken.
//  OUT data=0xBEEF, out_ready low 3 cycles -> in_ready=0, out_data stable; ready -> RUN.
//  HLT -> halted=1, in_ready=0, in_valid ignored; resume pulse -> halted=0, in_ready=1.
//  rst_n low during OUT_WAIT -> out_valid=0, flags=0, state RUN immediately (async).

Source files
------------

// File: rtl/simple_pkg.sv
// Shared definitions for the writeback stage: op codes, branch conditions, FSM states
// and decode helpers reused by the decode and ALU wrappers.
package simple_pkg;

    localparam int unsigned DataWDefault = 16;
    localparam int unsigned RaWDefault   = 3;

    typedef logic [3:0] op_t;
    typedef logic [2:0] cond_t;

    localparam op_t OpAdd = 4'b0000;
    localparam op_t OpSub = 4'b0001;
    localparam op_t OpAnd = 4'b0010;
    localparam op_t OpOr  = 4'b0011;
    localparam op_t OpXor = 4'b0100;
    localparam op_t OpCmp = 4'b0101;
    localparam op_t OpNot = 4'b0110;
    localparam op_t OpNop = 4'b0111;
    localparam op_t OpShl = 4'b1000;
    localparam op_t OpShr = 4'b1001;
    localparam op_t OpRol = 4'b1010;
    localparam op_t OpRor = 4'b1011;
    localparam op_t OpIn  = 4'b1100;
    localparam op_t OpOut = 4'b1101;
    localparam op_t OpRsv = 4'b1110;
    localparam op_t OpHlt = 4'b1111;

    localparam cond_t CondBe  = 3'b000;
    localparam cond_t CondBlt = 3'b001;
    localparam cond_t CondBle = 3'b010;
    localparam cond_t CondBne = 3'b011;
    localparam cond_t CondB   = 3'b100;

    // Bit positions inside the {S,Z,C,V} flag vector.
    localparam int unsigned FlagS = 3;
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagC = 1;
    localparam int unsigned FlagV = 0;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StOutWait = 2'd1,
        StHalted  = 2'd2
    } wb_state_e;

    function automatic logic op_writes_rf(input op_t op);
        logic we;
        case (op)
            OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNot,
            OpShl, OpShr, OpRol, OpRor, OpIn: we = 1'b1;
            default:                          we = 1'b0;
        endcase
        return we;
    endfunction

    function automatic logic op_sets_flags(input op_t op);
        logic fe;
        case (op)
            OpAdd, OpSub, OpAnd, OpOr, OpXor, OpCmp, OpNot,
            OpShl, OpShr, OpRol, OpRor: fe = 1'b1;
            default:                    fe = 1'b0;
        endcase
        return fe;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch resolution from the architectural S, Z and V flags.
module branch_cond_eval
    import simple_pkg::*;
(
    input  logic       flag_s,
    input  logic       flag_z,
    input  logic       flag_v,
    input  logic [2:0] cond,
    output logic       taken
);

    logic lt;

    assign lt = flag_s ^ flag_v;

    always_comb begin
        taken = 1'b0;
        case (cond)
            CondBe:  taken = flag_z;
            CondBlt: taken = lt;
            CondBle: taken = flag_z | lt;
            CondBne: taken = ~flag_z;
            CondB:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/simple_writeback.sv
// Execute/writeback stage: registers ALU results, owns the flag register, drives the
// register-file write port, resolves branches and sequences OUT and HLT.
module simple_writeback
    import simple_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned RA_W   = RaWDefault
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_res,
    input  logic [3:0]        in_szcv,
    input  logic [RA_W-1:0]   in_rd,
    input  logic              in_is_br,
    input  logic [2:0]        in_cond,
    input  logic [DATA_W-1:0] in_br_target,
    output logic              rf_we,
    output logic [RA_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [3:0]        flags,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              halted,
    input  logic              resume
);

    wb_state_e         state_q, state_d;
    logic              rf_we_q, rf_we_d;
    logic [RA_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [3:0]        flags_q, flags_d;
    logic              br_taken_q, br_taken_d;
    logic [DATA_W-1:0] br_pc_q, br_pc_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              halted_q, halted_d;
    logic              cond_taken;

    // Branches see the committed flag register; a preceding flag-setting op has already
    // updated it at its own acceptance edge, so no bypass is required.
    branch_cond_eval u_branch_cond_eval (
        .flag_s (flags_q[FlagS]),
        .flag_z (flags_q[FlagZ]),
        .flag_v (flags_q[FlagV]),
        .cond   (in_cond),
        .taken  (cond_taken)
    );

    assign in_ready = (state_q == StRun);

    always_comb begin
        state_d     = state_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        flags_d     = flags_q;
        br_taken_d  = 1'b0;
        br_pc_d     = br_pc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        halted_d    = halted_q;

        case (state_q)
            StRun: begin
                if (in_valid) begin
                    if (in_is_br) begin
                        if (cond_taken) begin
                            br_taken_d = 1'b1;
                            br_pc_d    = in_br_target;
                        end
                    end else begin
                        if (op_writes_rf(in_op)) begin
                            rf_we_d    = 1'b1;
                            rf_waddr_d = in_rd;
                            rf_wdata_d = in_res;
                        end
                        if (op_sets_flags(in_op)) begin
                            flags_d = in_szcv;
                        end
                        if (in_op == OpOut) begin
                            out_valid_d = 1'b1;
                            out_data_d  = in_res;
                            state_d     = StOutWait;
                        end
                        if (in_op == OpHlt) begin
                            halted_d = 1'b1;
                            state_d  = StHalted;
                        end
                    end
                end
            end
            StOutWait: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StRun;
                end
            end
            StHalted: begin
                if (resume) begin
                    halted_d = 1'b0;
                    state_d  = StRun;
                end
            end
            default: begin
                state_d     = StRun;
                out_valid_d = 1'b0;
                halted_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            flags_q     <= '0;
            br_taken_q  <= 1'b0;
            br_pc_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            flags_q     <= flags_d;
            br_taken_q  <= br_taken_d;
            br_pc_q     <= br_pc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            halted_q    <= halted_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign flags     = flags_q;
    assign br_taken  = br_taken_q;
    assign br_pc     = br_pc_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign halted    = halted_q;

    // The OUT consumer relies on data staying put until it takes it.
    a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

    a_wr_br_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(rf_we && br_taken));

endmodule

// File: tb/tb_simple_writeback.sv
// Scoreboard bench for simple_writeback: a cycle model pushes expected writes/branches
// at each edge and they are popped against the DUT outputs just after it.
module tb_simple_writeback;
    import simple_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [DW-1:0] in_res;
    logic [3:0]    in_szcv;
    logic [AW-1:0] in_rd;
    logic          in_is_br;
    logic [2:0]    in_cond;
    logic [DW-1:0] in_br_target;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [3:0]    flags;
    logic          br_taken;
    logic [DW-1:0] br_pc;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          halted;
    logic          resume;

    always #5 clk = ~clk;

    simple_writeback #(.DATA_W(DW), .RA_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_res       (in_res),
        .in_szcv      (in_szcv),
        .in_rd        (in_rd),
        .in_is_br     (in_is_br),
        .in_cond      (in_cond),
        .in_br_target (in_br_target),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .flags        (flags),
        .br_taken     (br_taken),
        .br_pc        (br_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .halted       (halted),
        .resume       (resume)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: 0 run, 1 waiting on OUT consumer, 2 halted.
    int            m_state;
    logic [3:0]    m_flags;
    logic          m_out_valid;
    logic [DW-1:0] m_out_data;
    logic          m_halted;
    logic [AW+DW-1:0] exp_wr_q[$];
    logic [DW-1:0]    exp_br_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic m_taken(input logic [2:0] c, input logic [3:0] f);
        logic s, z, v;
        s = f[3];
        z = f[2];
        v = f[0];
        case (c)
            3'd0:    return z;
            3'd1:    return s ^ v;
            3'd2:    return z | (s ^ v);
            3'd3:    return !z;
            3'd4:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic m_writes(input logic [3:0] op);
        return op inside {[4'd0:4'd4], 4'd6, [4'd8:4'd11], 4'd12};
    endfunction

    function automatic logic m_sets(input logic [3:0] op);
        return op inside {[4'd0:4'd6], [4'd8:4'd11]};
    endfunction

    task automatic model_reset();
        m_state     = 0;
        m_flags     = 4'b0;
        m_out_valid = 1'b0;
        m_out_data  = '0;
        m_halted    = 1'b0;
        exp_wr_q.delete();
        exp_br_q.delete();
    endtask

    task automatic model_edge();
        case (m_state)
            0: begin
                if (in_valid) begin
                    if (in_is_br) begin
                        if (m_taken(in_cond, m_flags)) exp_br_q.push_back(in_br_target);
                    end else begin
                        if (m_writes(in_op)) exp_wr_q.push_back({in_rd, in_res});
                        if (m_sets(in_op)) m_flags = in_szcv;
                        if (in_op == 4'b1101) begin
                            m_out_valid = 1'b1;
                            m_out_data  = in_res;
                            m_state     = 1;
                        end
                        if (in_op == 4'b1111) begin
                            m_halted = 1'b1;
                            m_state  = 2;
                        end
                    end
                end
            end
            1: if (out_ready) begin
                m_out_valid = 1'b0;
                m_state     = 0;
            end
            default: if (resume) begin
                m_halted = 1'b0;
                m_state  = 0;
            end
        endcase
    endtask

    task automatic compare();
        logic [AW+DW-1:0] w;
        logic [DW-1:0]    b;
        check("in_ready", 32'(in_ready), 32'(m_state == 0));
        if (exp_wr_q.size() > 0) begin
            w = exp_wr_q.pop_front();
            check("rf_we", 32'(rf_we), 32'd1);
            check("rf_waddr", 32'(rf_waddr), 32'(w[DW +: AW]));
            check("rf_wdata", 32'(rf_wdata), 32'(w[DW-1:0]));
        end else begin
            check("rf_we", 32'(rf_we), 32'd0);
        end
        if (exp_br_q.size() > 0) begin
            b = exp_br_q.pop_front();
            check("br_taken", 32'(br_taken), 32'd1);
            check("br_pc", 32'(br_pc), 32'(b));
        end else begin
            check("br_taken", 32'(br_taken), 32'd0);
        end
        check("flags", 32'(flags), 32'(m_flags));
        check("out_valid", 32'(out_valid), 32'(m_out_valid));
        if (m_out_valid) check("out_data", 32'(out_data), 32'(m_out_data));
        check("halted", 32'(halted), 32'(m_halted));
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] op, input logic [DW-1:0] res,
                         input logic [3:0] szcv, input logic [AW-1:0] rd);
        in_valid     = 1'b1;
        in_is_br     = 1'b0;
        in_op        = op;
        in_res       = res;
        in_szcv      = szcv;
        in_rd        = rd;
        in_cond      = 3'($urandom);
        in_br_target = DW'($urandom);
    endtask

    task automatic drive_br(input logic [2:0] cond, input logic [DW-1:0] tgt);
        in_valid     = 1'b1;
        in_is_br     = 1'b1;
        in_op        = 4'($urandom);
        in_res       = DW'($urandom);
        in_szcv      = 4'($urandom);
        in_rd        = AW'($urandom);
        in_cond      = cond;
        in_br_target = tgt;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_is_br = 1'($urandom);
        in_op    = 4'($urandom);
        in_res   = DW'($urandom);
        in_szcv  = 4'($urandom);
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_op        = '0;
        in_res       = '0;
        in_szcv      = '0;
        in_rd        = '0;
        in_is_br     = 1'b0;
        in_cond      = '0;
        in_br_target = '0;
        out_ready    = 1'b0;
        resume       = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        rst_n = 1'b1;

        // ADD result lands on the write port one cycle later.
        drive(OpAdd, 16'h0003, 4'b0000, 3'd2);
        cycle();
        // CMP sets Z only; the back-to-back BE must see it.
        drive(OpCmp, 16'h1234, 4'b0100, 3'd5);
        cycle();
        drive_br(CondBe, 16'h0040);
        cycle();
        idle();
        cycle();

        // S=1, V=0, Z=0: sweep every condition code.
        drive(OpSub, 16'h8000, 4'b1000, 3'd1);
        cycle();
        for (int c = 0; c < 8; c++) begin
            drive_br(3'(c), 16'h0100 + 16'(c));
            cycle();
        end
        idle();
        cycle();

        // Every non-sequencing op back-to-back.
        for (int op = 0; op < 16; op++) begin
            if (op != 13 && op != 15) begin
                drive(4'(op), DW'($urandom), 4'($urandom), AW'($urandom));
                cycle();
            end
        end

        // OUT with a stalled consumer; the pending instruction must be ignored.
        drive(OpOut, 16'hBEEF, 4'b1111, 3'd0);
        out_ready = 1'b0;
        cycle();
        drive(OpAdd, 16'h5555, 4'b0001, 3'd7);
        repeat (3) begin
            cycle();
            check("out_hold", 32'(out_data), 32'h0000_BEEF);
        end
        out_ready = 1'b1;
        idle();
        cycle();
        out_ready = 1'b0;
        cycle();

        // HLT ignores in_valid until resume.
        drive(OpHlt, 16'h0, 4'b0, 3'd0);
        cycle();
        drive(OpAdd, 16'h7777, 4'b0010, 3'd3);
        repeat (3) cycle();
        resume = 1'b1;
        idle();
        cycle();
        resume = 1'b0;
        cycle();

        // resume while running has no effect.
        resume = 1'b1;
        drive(OpXor, 16'h00F0, 4'b0000, 3'd4);
        cycle();
        resume = 1'b0;

        // Asynchronous reset in the middle of an OUT wait.
        drive(OpSub, 16'h0001, 4'b1011, 3'd6);
        cycle();
        drive(OpOut, 16'hCAFE, 4'b0000, 3'd0);
        cycle();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Random traffic with random consumer readiness and resume pulses.
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) begin
                drive_br(3'($urandom), DW'($urandom));
            end else if ($urandom_range(0, 3) != 0) begin
                drive(4'($urandom_range(0, 15)), DW'($urandom), 4'($urandom), AW'($urandom));
            end else begin
                idle();
            end
            out_ready = 1'($urandom);
            resume    = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
